// File: rtl/axi_meta_arb_pkg.sv
// Shared types and sizes for the two-master meta AXI4 arbiter in front of ddr_sdram_ctrl.
package axi_meta_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int LEN_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WDATA = 3'd2,
    ST_WRESP = 3'd3,
    ST_RADDR = 3'd4,
    ST_RDATA = 3'd5
  } state_e;

endpackage

// File: rtl/axi_meta_rr_pick.sv
// Registered 2-way round-robin picker; also chooses write vs read when a master has both pending.
module axi_meta_rr_pick
  import axi_meta_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_aw_req,
  input  logic [NUM_REQ-1:0] i_ar_req,
  input  logic               i_pick_en,
  input  logic               i_done,
  output logic               o_req_any,
  output logic               o_pick_write,
  output logic               o_grant_id
);

  logic [NUM_REQ-1:0] w_req;
  logic               w_pick_id;
  logic               w_pick_aw;
  logic               w_pick_ar;
  logic               w_both;

  logic               r_rr_ptr;
  logic [NUM_REQ-1:0] r_op_toggle;
  logic               r_grant_id;

  assign w_req     = i_aw_req | i_ar_req;
  assign o_req_any = |w_req;

  // rr_ptr only matters when both masters compete; a lone requester always wins.
  assign w_pick_id = (&w_req) ? r_rr_ptr : w_req[1];
  assign w_pick_aw = i_aw_req[w_pick_id];
  assign w_pick_ar = i_ar_req[w_pick_id];
  assign w_both    = w_pick_aw & w_pick_ar;

  assign o_pick_write = w_both ? ~r_op_toggle[w_pick_id] : w_pick_aw;
  assign o_grant_id   = r_grant_id;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= 1'b0;
      r_op_toggle <= '0;
      r_grant_id  <= 1'b0;
    end else begin
      if (i_pick_en && o_req_any) begin
        r_grant_id <= w_pick_id;
        if (w_both) r_op_toggle[w_pick_id] <= ~r_op_toggle[w_pick_id];
      end
      if (i_done) r_rr_ptr <= ~r_grant_id;
    end
  end

endmodule

// File: rtl/axi_meta_arbiter2.sv
// Arbitrates two meta AXI4 masters onto the single ddr_sdram_ctrl slave port, one burst at a time.
module axi_meta_arbiter2
  import axi_meta_arb_pkg::*;
#(
  parameter int A_WIDTH = 25,
  parameter int D_WIDTH = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  // master 0
  input  logic               s0_awvalid,
  output logic               s0_awready,
  input  logic [A_WIDTH-1:0] s0_awaddr,
  input  logic [7:0]         s0_awlen,
  input  logic               s0_wvalid,
  output logic               s0_wready,
  input  logic               s0_wlast,
  input  logic [D_WIDTH-1:0] s0_wdata,
  output logic               s0_bvalid,
  input  logic               s0_bready,
  input  logic               s0_arvalid,
  output logic               s0_arready,
  input  logic [A_WIDTH-1:0] s0_araddr,
  input  logic [7:0]         s0_arlen,
  output logic               s0_rvalid,
  input  logic               s0_rready,
  output logic               s0_rlast,
  output logic [D_WIDTH-1:0] s0_rdata,
  // master 1
  input  logic               s1_awvalid,
  output logic               s1_awready,
  input  logic [A_WIDTH-1:0] s1_awaddr,
  input  logic [7:0]         s1_awlen,
  input  logic               s1_wvalid,
  output logic               s1_wready,
  input  logic               s1_wlast,
  input  logic [D_WIDTH-1:0] s1_wdata,
  output logic               s1_bvalid,
  input  logic               s1_bready,
  input  logic               s1_arvalid,
  output logic               s1_arready,
  input  logic [A_WIDTH-1:0] s1_araddr,
  input  logic [7:0]         s1_arlen,
  output logic               s1_rvalid,
  input  logic               s1_rready,
  output logic               s1_rlast,
  output logic [D_WIDTH-1:0] s1_rdata,
  // controller side
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [A_WIDTH-1:0] m_awaddr,
  output logic [7:0]         m_awlen,
  output logic               m_wvalid,
  input  logic               m_wready,
  output logic               m_wlast,
  output logic [D_WIDTH-1:0] m_wdata,
  input  logic               m_bvalid,
  output logic               m_bready,
  output logic               m_arvalid,
  input  logic               m_arready,
  output logic [A_WIDTH-1:0] m_araddr,
  output logic [7:0]         m_arlen,
  input  logic               m_rvalid,
  output logic               m_rready,
  input  logic               m_rlast,
  input  logic [D_WIDTH-1:0] m_rdata,
  // status
  output logic               grant_id,
  output logic               busy,
  output logic               wlast_err
);

  logic [NUM_REQ-1:0] w_awvalid, w_wvalid, w_wlast, w_bready, w_arvalid, w_rready;
  logic [NUM_REQ-1:0] w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic [A_WIDTH-1:0] w_awaddr [NUM_REQ];
  logic [A_WIDTH-1:0] w_araddr [NUM_REQ];
  logic [LEN_W-1:0]   w_awlen  [NUM_REQ];
  logic [LEN_W-1:0]   w_arlen  [NUM_REQ];
  logic [D_WIDTH-1:0] w_wdata  [NUM_REQ];

  state_e             r_state, w_next;
  logic [LEN_W-1:0]   r_awlen;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_wlast_err;

  logic w_g, w_req_any, w_pick_write;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_done;

  assign w_awvalid = {s1_awvalid, s0_awvalid};
  assign w_wvalid  = {s1_wvalid,  s0_wvalid};
  assign w_wlast   = {s1_wlast,   s0_wlast};
  assign w_bready  = {s1_bready,  s0_bready};
  assign w_arvalid = {s1_arvalid, s0_arvalid};
  assign w_rready  = {s1_rready,  s0_rready};
  assign w_awaddr[0] = s0_awaddr;  assign w_awaddr[1] = s1_awaddr;
  assign w_araddr[0] = s0_araddr;  assign w_araddr[1] = s1_araddr;
  assign w_awlen[0]  = s0_awlen;   assign w_awlen[1]  = s1_awlen;
  assign w_arlen[0]  = s0_arlen;   assign w_arlen[1]  = s1_arlen;
  assign w_wdata[0]  = s0_wdata;   assign w_wdata[1]  = s1_wdata;

  axi_meta_rr_pick u_pick (
    .clk          (aclk),
    .rst_n        (aresetn),
    .i_aw_req     (w_awvalid),
    .i_ar_req     (w_arvalid),
    .i_pick_en    (r_state == ST_IDLE),
    .i_done       (w_done),
    .o_req_any    (w_req_any),
    .o_pick_write (w_pick_write),
    .o_grant_id   (w_g)
  );

  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;
  assign w_b_hs  = m_bvalid & m_bready;
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = m_rvalid & m_rready;
  assign w_done  = w_b_hs | (w_r_hs & m_rlast);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_req_any) w_next = w_pick_write ? ST_WADDR : ST_RADDR;
      ST_WADDR: if (w_aw_hs) w_next = ST_WDATA;
      ST_WDATA: if (w_w_hs && m_wlast) w_next = ST_WRESP;
      ST_WRESP: if (w_b_hs) w_next = ST_IDLE;
      ST_RADDR: if (w_ar_hs) w_next = ST_RDATA;
      ST_RDATA: if (w_r_hs && m_rlast) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Address/data paths follow grant_id unconditionally; only valid/ready are gated by state.
  assign m_awaddr = w_awaddr[w_g];
  assign m_awlen  = w_awlen[w_g];
  assign m_wdata  = w_wdata[w_g];
  assign m_wlast  = w_wlast[w_g];
  assign m_araddr = w_araddr[w_g];
  assign m_arlen  = w_arlen[w_g];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    w_awready = '0;
    w_wready  = '0;
    w_bvalid  = '0;
    w_arready = '0;
    w_rvalid  = '0;
    unique case (r_state)
      ST_WADDR: begin m_awvalid = w_awvalid[w_g]; w_awready[w_g] = m_awready; end
      ST_WDATA: begin m_wvalid  = w_wvalid[w_g];  w_wready[w_g]  = m_wready;  end
      ST_WRESP: begin m_bready  = w_bready[w_g];  w_bvalid[w_g]  = m_bvalid;  end
      ST_RADDR: begin m_arvalid = w_arvalid[w_g]; w_arready[w_g] = m_arready; end
      ST_RDATA: begin m_rready  = w_rready[w_g];  w_rvalid[w_g]  = m_rvalid;  end
      default: ;
    endcase
  end

  assign s0_awready = w_awready[0];  assign s1_awready = w_awready[1];
  assign s0_wready  = w_wready[0];   assign s1_wready  = w_wready[1];
  assign s0_bvalid  = w_bvalid[0];   assign s1_bvalid  = w_bvalid[1];
  assign s0_arready = w_arready[0];  assign s1_arready = w_arready[1];
  assign s0_rvalid  = w_rvalid[0];   assign s1_rvalid  = w_rvalid[1];
  assign s0_rdata   = m_rdata;       assign s1_rdata   = m_rdata;
  assign s0_rlast   = m_rlast;       assign s1_rlast   = m_rlast;

  // Beat counter checks wlast placement against the latched awlen.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awlen     <= '0;
      r_beat_cnt  <= '0;
      r_wlast_err <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_awlen    <= m_awlen;
        r_beat_cnt <= '0;
      end
      if (w_w_hs) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
        if (m_wlast != (r_beat_cnt == r_awlen)) r_wlast_err <= 1'b1;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = busy & w_g;
  assign wlast_err = r_wlast_err;

endmodule

// File: tb/tb_axi_meta_arbiter2.sv
// Directed + randomized bench: two master drivers, a memory-backed controller model, and a reference memory.
module tb_axi_meta_arbiter2;

  localparam int AW     = 25;
  localparam int DW     = 16;
  localparam int BUDGET = 200;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [1:0]    s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_awaddr [2];
  logic [AW-1:0] s_araddr [2];
  logic [7:0]    s_awlen  [2];
  logic [7:0]    s_arlen  [2];
  logic [DW-1:0] s_wdata  [2];
  logic [DW-1:0] s_rdata  [2];

  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [7:0]    m_awlen, m_arlen;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          grant_id, busy, wlast_err;

  axi_meta_arbiter2 #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awaddr(s_awaddr[0]), .s0_awlen(s_awlen[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]), .s0_wlast(s_wlast[0]), .s0_wdata(s_wdata[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]), .s0_arlen(s_arlen[0]),
    .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rlast(s_rlast[0]), .s0_rdata(s_rdata[0]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awaddr(s_awaddr[1]), .s1_awlen(s_awlen[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]), .s1_wlast(s_wlast[1]), .s1_wdata(s_wdata[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]), .s1_arlen(s_arlen[1]),
    .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rlast(s_rlast[1]), .s1_rdata(s_rdata[1]),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .grant_id(grant_id), .busy(busy), .wlast_err(wlast_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] ref_mem  [1024];
  logic [DW-1:0] slv_mem  [1024];

  function automatic logic [DW-1:0] init_word(int i);
    return DW'(i * 7) ^ 16'hC3A5;
  endfunction

  function automatic int idx(logic [AW-1:0] a);
    return (int'(a) >> 1) & 1023;
  endfunction

  task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Controller model: memory-backed, random ready/valid timing, obeys AXI valid hold rules.
  initial begin : controller_model
    int wptr, rptr, rleft;
    logic bpend, rhold;
    wptr = 0; rptr = 0; rleft = 0; bpend = 1'b0; rhold = 1'b0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0;
    m_rvalid = 0; m_rlast = 0; m_rdata = '0;
    for (int i = 0; i < 1024; i++) slv_mem[i] = init_word(i);
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        bpend = 1'b0; rleft = 0; rhold = 1'b0;
      end else begin
        if (m_awvalid && m_awready) wptr = idx(m_awaddr);
        if (m_wvalid && m_wready) begin
          slv_mem[wptr & 1023] = m_wdata;
          wptr++;
          if (m_wlast) bpend = 1'b1;
        end
        if (m_bvalid && m_bready) bpend = 1'b0;
        if (m_arvalid && m_arready) begin rptr = idx(m_araddr); rleft = int'(m_arlen) + 1; end
        rhold = m_rvalid && !m_rready;
        if (m_rvalid && m_rready) begin rptr++; rleft--; end
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0; m_rlast = 0;
      end else begin
        m_awready = ($urandom % 4) != 0;
        m_wready  = ($urandom % 4) != 0;
        m_arready = ($urandom % 4) != 0;
        m_bvalid  = bpend && (m_bvalid || ($urandom % 2) == 0);
        if (rleft == 0)  m_rvalid = 0;
        else if (!rhold) m_rvalid = ($urandom % 4) != 0;
        m_rdata = slv_mem[rptr & 1023];
        m_rlast = (rleft == 1);
      end
    end
  end

  // Passive monitor: grant events, busy edges and leakage toward the non-granted master.
  int          cyc = 0;
  logic        prev_busy = 1'b0;
  int          start_q[$];
  int          end_q[$];
  logic [1:0]  gq[$];
  int          other_seen = 0;

  always @(negedge aclk) begin
    cyc++;
    if (busy && !prev_busy) begin
      start_q.push_back(cyc);
      gq.push_back({grant_id, m_awvalid});
    end
    if (!busy && prev_busy) end_q.push_back(cyc);
    if (busy && (s_awready[!grant_id] | s_wready[!grant_id] | s_bvalid[!grant_id] |
                 s_arready[!grant_id] | s_rvalid[!grant_id]))
      other_seen++;
    prev_busy = busy;
  end

  task automatic wr(input int id, input logic [AW-1:0] addr, input logic [7:0] len,
                    input int last_at, input logic [DW-1:0] dbase, input bit keep);
    int t;
    s_awaddr[id] = addr; s_awlen[id] = len; s_awvalid[id] = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_awready[id] && t < BUDGET) begin @(negedge aclk); t++; end
    if (!s_awready[id]) begin check("aw_timeout", s_awready[id], 1); return; end
    tick();
    if (!keep) s_awvalid[id] = 1'b0;
    for (int k = 0; k <= last_at; k++) begin
      s_wvalid[id] = 1'b1; s_wdata[id] = dbase + DW'(k); s_wlast[id] = (k == last_at);
      t = 0;
      @(negedge aclk);
      while (!s_wready[id] && t < BUDGET) begin @(negedge aclk); t++; end
      if (!s_wready[id]) begin check("w_timeout", s_wready[id], 1); return; end
      tick();
      ref_mem[(idx(addr) + k) & 1023] = dbase + DW'(k);
    end
    s_wvalid[id] = 1'b0; s_wlast[id] = 1'b0;
    repeat ($urandom % 3) tick();
    s_bready[id] = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_bvalid[id] && t < BUDGET) begin @(negedge aclk); t++; end
    if (!s_bvalid[id]) begin check("b_timeout", s_bvalid[id], 1); return; end
    tick();
    s_bready[id] = 1'b0;
  endtask

  // mode: 0 = rready held high, 1 = rready alternates 1,0,1,0, 2 = random rready
  task automatic rd(input int id, input logic [AW-1:0] addr, input logic [7:0] len,
                    input int mode, input bit keep);
    int t, beats;
    s_araddr[id] = addr; s_arlen[id] = len; s_arvalid[id] = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_arready[id] && t < BUDGET) begin @(negedge aclk); t++; end
    if (!s_arready[id]) begin check("ar_timeout", s_arready[id], 1); return; end
    tick();
    if (!keep) s_arvalid[id] = 1'b0;
    s_rready[id] = 1'b1;
    beats = 0; t = 0;
    while (beats <= int'(len) && t < BUDGET) begin
      @(negedge aclk);
      if (mode == 1) check("m_rready_follow", m_rready, s_rready[id]);
      if (s_rvalid[id] && s_rready[id]) begin
        check("rdata", s_rdata[id], ref_mem[(idx(addr) + beats) & 1023]);
        check("rlast", s_rlast[id], beats == int'(len));
        beats++;
      end
      tick();
      t++;
      case (mode)
        0:       s_rready[id] = 1'b1;
        1:       s_rready[id] = ~s_rready[id];
        default: s_rready[id] = 1'($urandom % 2);
      endcase
    end
    s_rready[id] = 1'b0;
    check("rd_beats", beats, int'(len) + 1);
  endtask

  task automatic clear_inputs();
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = '0; s_araddr[i] = '0; s_awlen[i] = '0; s_arlen[i] = '0; s_wdata[i] = '0;
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t, beats, id;
    logic [7:0] len;
    logic [AW-1:0] addr;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    clear_inputs();
    aresetn = 1'b0;

    // Reset state with requests already pending: nothing may leak out.
    s_awvalid = 2'b11; s_arvalid = 2'b11;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_wlast_err", wlast_err, 0);
    check("rst_m_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
    check("rst_m_readys", {m_rready, m_bready}, 0);
    check("rst_s_handshakes", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 0);
    clear_inputs();
    aresetn = 1'b1;
    tick();

    // Both masters raise awvalid together: s0 first, one IDLE cycle, then s1.
    start_q.delete(); end_q.delete(); gq.delete();
    s_awaddr[1] = 25'h200; s_awlen[1] = 8'd3; s_awvalid[1] = 1'b1;
    wr(0, 25'h180, 8'd3, 3, 16'h1000, 1'b0);
    wr(1, 25'h200, 8'd3, 3, 16'h2000, 1'b0);
    check("dual_grants", gq.size(), 2);
    if (gq.size() >= 2) begin
      check("dual_first", gq[0], 2'b01);
      check("dual_second", gq[1], 2'b11);
    end
    if (start_q.size() >= 2 && end_q.size() >= 1)
      check("dual_idle_gap", start_q[1] - end_q[0], 1);
    rd(0, 25'h180, 8'd3, 0, 1'b0);
    rd(1, 25'h200, 8'd3, 0, 1'b0);

    // 8-beat write then read back on s0; s1 must see nothing.
    other_seen = 0;
    wr(0, 25'h100, 8'd7, 7, 16'h0000, 1'b0);
    rd(0, 25'h100, 8'd7, 0, 1'b0);
    check("s1_quiet", other_seen, 0);
    check("wlast_err_clean", wlast_err, 0);

    // s0 with aw and ar pending together: ops alternate W, R, W, R.
    gq.delete();
    s_araddr[0] = 25'h100; s_arlen[0] = 8'd7; s_arvalid[0] = 1'b1;
    wr(0, 25'h300, 8'd1, 1, 16'h3000, 1'b1);
    rd(0, 25'h100, 8'd7, 0, 1'b1);
    wr(0, 25'h300, 8'd1, 1, 16'h3100, 1'b0);
    rd(0, 25'h300, 8'd1, 0, 1'b0);
    check("toggle_ops", gq.size(), 4);
    if (gq.size() >= 4) check("toggle_pattern", {gq[0][0], gq[1][0], gq[2][0], gq[3][0]}, 4'b1010);

    // rready backpressure on s1: alternate 1,0,1,0 with no data loss.
    rd(1, 25'h100, 8'd7, 1, 1'b0);

    // Early wlast: beat 3 of an awlen=7 burst.
    wr(0, 25'h400, 8'd7, 3, 16'h4000, 1'b0);
    check("wlast_err_set", wlast_err, 1);
    check("wlast_err_idle", busy, 0);
    wr(1, 25'h420, 8'd0, 0, 16'h4200, 1'b0);
    check("wlast_err_sticky", wlast_err, 1);
    rd(1, 25'h400, 8'd3, 0, 1'b0);
    rd(0, 25'h420, 8'd0, 2, 1'b0);

    // Randomized single-master transactions checked against the reference memory.
    for (int n = 0; n < 24; n++) begin
      id   = int'($urandom % 2);
      len  = 8'($urandom % 16);
      addr = AW'(($urandom % 64) * 32);
      if ($urandom % 2) wr(id, addr, len, int'(len), DW'($urandom), 1'b0);
      else              rd(id, addr, len, 2, 1'b0);
      if (gq.size() > 0) check("rand_grant_id", gq[$][1], id);
    end
    check("overall_quiet", other_seen, 0);

    // Reset in the middle of an RDATA burst.
    s_araddr[0] = 25'h100; s_arlen[0] = 8'd7; s_arvalid[0] = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_arready[0] && t < BUDGET) begin @(negedge aclk); t++; end
    check("rst_mid_ar", s_arready[0], 1);
    tick();
    s_arvalid[0] = 1'b0; s_rready[0] = 1'b1;
    beats = 0; t = 0;
    while (beats < 3 && t < BUDGET) begin
      @(negedge aclk);
      if (s_rvalid[0]) beats++;
      tick();
      t++;
    end
    @(negedge aclk);
    check("rst_mid_busy_before", busy, 1);
    #2 aresetn = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_grant", grant_id, 0);
    check("rst_mid_outputs", {m_rready, m_bready, m_awvalid, m_wvalid, m_arvalid, s_rvalid}, 0);
    check("rst_mid_wlast_err", wlast_err, 0);
    clear_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    gq.delete();
    rd(1, 25'h040, 8'd5, 0, 1'b0);
    check("post_rst_grants", gq.size(), 1);
    if (gq.size() >= 1) check("post_rst_grant", gq[0], 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
